sd_spi_arbiter: RTL and testbench
=================================

# sd_spi_arbiter

Shares the single SD-card SPI port between two byte-level clients: client 0 is the CPU-facing divMMC/Z-Controller port logic, and client 1 is the autonomous boot/sector loader. It owns the serial shift engine and the physical sd_sck/sd_mosi/sd_cs pins. Bus ownership is locked per chip-select transaction, so commands from the two clients are never interleaved on the card. It sits between the port decoders and the SD connector pins.

## Interface
- PRIO, default 1: client index that wins when both clients request in the same clk28 cycle with no owner locked.
- rst_n  in  1  asynchronous, active-low reset
- clk28  in  1  system clock
- ck14  in  1  one-clk28 strobe every 2 cycles
- ck7  in  1  one-clk28 strobe every 4 cycles; always coincides with a ck14 strobe
- cN_start  in  1  (N=0,1) one-cycle byte-transfer request
- cN_txd  in  8  byte to send; captured on cN_start
- cN_cs_n  in  1  client's requested chip-select level; low = wants/holds the card
- cN_busy  out  1  request pending or in flight for client N
- cN_done  out  1  one-cycle pulse when client N's byte completes
- cN_rxd  out  8  last byte received for client N
- sd_miso  in  1  card data out
- sd_sck  out  1  SPI clock, mode 0
- sd_mosi  out  1  card data in
- sd_cs  out  1  card select, active low
- owner  out  2  {locked, index}: bit1 set while a client holds the bus, bit0 is that client

## Operation
- Reset values: sd_cs=1, sd_sck=0, sd_mosi=1, owner=00, cN_busy=0, cN_done=0, cN_rxd=8'hFF, all pending flags clear.
- Per-client pending latch: cN_start while cN_busy=0 stores cN_txd and sets pending (cN_busy=1 the next cycle). cN_start while cN_busy=1 is ignored.
- Arbiter states:
  - UNLOCKED: a client is eligible when it is pending or its cN_cs_n=0. With one eligible client, grant it. With both eligible, grant PRIO. Granting sets owner={1,N}. The grant completes in one cycle.
  - LOCKED(N): sd_cs = cN_cs_n. Only client N's pending byte may start. The other client's request waits with busy held high.
  - LOCKED returns to UNLOCKED when the engine is IDLE, client N is not pending, and cN_cs_n=1. sd_cs goes to 1 in that same cycle.
  - Any cN_cs_n changes from a non-owner are ignored.
- Engine states:
  - IDLE: when LOCKED and the owner is pending, load the shift register from the latched byte, clear pending, and go to ARM.
  - ARM: wait for the next ck7, then enter SHIFT with bit_cnt=0.
  - SHIFT:
    - sd_mosi = shreg[7].
    - On the first ck14 after entering the bit that is not ck7: sd_sck←1 and miso_s←sd_miso.
    - On ck7: sd_sck←0, shreg←{shreg[6:0],miso_s}, bit_cnt+1.
    - After the 8th ck7, go to DONE.
  - DONE: for one cycle, cN_rxd←shreg, pulse cN_done, set cN_busy=0 unless the client is pending again. Then go to IDLE.
- sd_mosi=1 whenever the engine is not in SHIFT.
- bit_cnt is 3 bits. The terminal count is detected at bit_cnt==7 coinciding with ck7. There is no wrap-around into a 9th bit.
- Simultaneous events:
  - Owner releases cs in the same cycle the other client starts: the release completes first; the other client is granted the following cycle.
  - cN_start in the DONE cycle of its own byte is accepted, because busy is already low in DONE.
- Reset mid-transfer returns every register to its reset value immediately. A partial byte is discarded and no done pulse is issued.

## Timing
- cN_start at cycle T with the bus already owned by N: pending at T+1, ARM at T+2, SHIFT from the next ck7 after T+2.
- SHIFT lasts exactly 8 ck7 periods (32 clk28 cycles).
- cN_done is asserted the cycle after the 8th ck7. cN_rxd is valid from then on and holds until the next DONE for the same client.
- Worst-case start-to-done for the owner is 3 + 3 + 32 + 1 = 39 clk28 cycles.
- sd_sck is high for 2 clk28 cycles per bit. The card samples MOSI on the rising edge; MOSI changes only at ck7 (the falling edge).
- Grant latency from UNLOCKED is 1 cycle. sd_cs falls on the grant cycle, which is at least one ck7 period before the first sck rise.

## Test plan
- Single byte: c0_cs_n=0, c0_start with txd=8'hA5, sd_miso driven with 8'h3C bit-serially. Required: MOSI carries A5 MSB first, 8 sck pulses, c0_done after 32±7 cycles, c0_rxd=8'h3C, owner=10.
- Lock hold: client 0 owns (cs_n=0) and sends two bytes; c1_start is asserted between them. Required: client 1 stays busy and no c1 byte appears on MOSI until c0_cs_n=1. Then owner=11, sd_cs follows c1_cs_n, and c1's byte is sent.
- Simultaneous request with PRIO=1: both clients start in the same unlocked cycle. Required: client 1 is granted first; client 0's byte follows after c1_cs_n rises.
- Start ignored while busy: a second c0_start during SHIFT with txd=8'h00. Required: the first byte completes unchanged and only one c0_done is issued.
- Reset mid-SHIFT at bit 4. Required: sd_cs=1, sd_sck=0, sd_mosi=1, busy=0, rxd=FF, no done pulse. A fresh transfer after reset completes normally.
- Back-to-back: c0_start in the DONE cycle. Required: the second byte begins at the next ck7 after ARM, and sd_cs stays low throughout with no release glitch.

Source files
------------

// File: rtl/sd_spi_arbiter.sv
// rtl/sd_spi_arbiter.sv - two-client SD SPI arbiter with per-chip-select bus locking
// Owns the mode-0 shift engine and sd_sck/sd_mosi/sd_cs; byte requests latch per client.
module sd_spi_arbiter #(
  parameter int PRIO = 1
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck14_i,
  input  logic       ck7_i,
  input  logic       c0_start_i,
  input  logic [7:0] c0_txd_i,
  input  logic       c0_cs_n_i,
  output logic       c0_busy_o,
  output logic       c0_done_o,
  output logic [7:0] c0_rxd_o,
  input  logic       c1_start_i,
  input  logic [7:0] c1_txd_i,
  input  logic       c1_cs_n_i,
  output logic       c1_busy_o,
  output logic       c1_done_o,
  output logic [7:0] c1_rxd_o,
  input  logic       sd_miso_i,
  output logic       sd_sck_o,
  output logic       sd_mosi_o,
  output logic       sd_cs_o,
  output logic [1:0] owner_o
);

  localparam logic PRIO_IDX = (PRIO != 0);

  typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_t;
  typedef enum logic [1:0] {ENG_IDLE, ENG_ARM, ENG_SHIFT, ENG_DONE} eng_t;

  arb_t       arb_q, arb_d;
  eng_t       eng_q, eng_d;
  logic       idx_q, idx_d;
  logic [1:0] pend_q, pend_d;
  logic [7:0] txd0_q, txd0_d;
  logic [7:0] txd1_q, txd1_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sck_q, sck_d;
  logic       miso_q, miso_d;
  logic [7:0] rxd0_q, rxd0_d;
  logic [7:0] rxd1_q, rxd1_d;

  logic [1:0] start;
  logic [1:0] cs_n;
  logic [1:0] busy;
  logic [1:0] elig;
  logic       in_flight;
  logic       locked;

  assign start     = {c1_start_i, c0_start_i};
  assign cs_n      = {c1_cs_n_i, c0_cs_n_i};
  assign locked    = (arb_q == ARB_LOCKED);
  assign in_flight = (eng_q == ENG_ARM) || (eng_q == ENG_SHIFT);
  assign elig      = pend_q | ~cs_n;

  // Busy drops combinationally in DONE so a start in that cycle is accepted.
  assign busy[0] = pend_q[0] | (in_flight & ~idx_q);
  assign busy[1] = pend_q[1] | (in_flight & idx_q);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      arb_q     <= ARB_UNLOCKED;
      eng_q     <= ENG_IDLE;
      idx_q     <= 1'b0;
      pend_q    <= 2'b00;
      txd0_q    <= 8'hFF;
      txd1_q    <= 8'hFF;
      shreg_q   <= 8'hFF;
      bit_cnt_q <= 3'd0;
      sck_q     <= 1'b0;
      miso_q    <= 1'b1;
      rxd0_q    <= 8'hFF;
      rxd1_q    <= 8'hFF;
    end else begin
      arb_q     <= arb_d;
      eng_q     <= eng_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      txd0_q    <= txd0_d;
      txd1_q    <= txd1_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      miso_q    <= miso_d;
      rxd0_q    <= rxd0_d;
      rxd1_q    <= rxd1_d;
    end
  end

  always_comb begin
    arb_d     = arb_q;
    eng_d     = eng_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    txd0_d    = txd0_q;
    txd1_d    = txd1_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    miso_d    = miso_q;
    rxd0_d    = rxd0_q;
    rxd1_d    = rxd1_q;

    if (start[0] && !busy[0]) begin
      pend_d[0] = 1'b1;
      txd0_d    = c0_txd_i;
    end
    if (start[1] && !busy[1]) begin
      pend_d[1] = 1'b1;
      txd1_d    = c1_txd_i;
    end

    case (arb_q)
      ARB_UNLOCKED: begin
        if (elig != 2'b00) begin
          arb_d = ARB_LOCKED;
          idx_d = (elig == 2'b11) ? PRIO_IDX : elig[1];
        end
      end
      ARB_LOCKED: begin
        if (eng_q == ENG_IDLE && !pend_q[idx_q] && cs_n[idx_q]) begin
          arb_d = ARB_UNLOCKED;
        end
      end
      default: arb_d = ARB_UNLOCKED;
    endcase

    case (eng_q)
      ENG_IDLE: begin
        if (locked && pend_q[idx_q]) begin
          shreg_d        = idx_q ? txd1_q : txd0_q;
          pend_d[idx_q]  = 1'b0;
          eng_d          = ENG_ARM;
        end
      end
      ENG_ARM: begin
        if (ck7_i) begin
          eng_d     = ENG_SHIFT;
          bit_cnt_d = 3'd0;
        end
      end
      ENG_SHIFT: begin
        // ck7 is the falling edge: shift in the bit sampled at the rising edge.
        if (ck7_i) begin
          sck_d     = 1'b0;
          shreg_d   = {shreg_q[6:0], miso_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            eng_d = ENG_DONE;
            if (idx_q) begin
              rxd1_d = {shreg_q[6:0], miso_q};
            end else begin
              rxd0_d = {shreg_q[6:0], miso_q};
            end
          end
        end else if (ck14_i) begin
          sck_d  = 1'b1;
          miso_d = sd_miso_i;
        end
      end
      ENG_DONE: begin
        eng_d = ENG_IDLE;
      end
      default: eng_d = ENG_IDLE;
    endcase
  end

  assign sd_sck_o  = sck_q;
  assign sd_mosi_o = (eng_q == ENG_SHIFT) ? shreg_q[7] : 1'b1;
  assign sd_cs_o   = locked ? cs_n[idx_q] : 1'b1;
  assign owner_o   = {locked, locked & idx_q};

  assign c0_busy_o = busy[0];
  assign c1_busy_o = busy[1];
  assign c0_done_o = (eng_q == ENG_DONE) && !idx_q;
  assign c1_done_o = (eng_q == ENG_DONE) && idx_q;
  assign c0_rxd_o  = rxd0_q;
  assign c1_rxd_o  = rxd1_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb/tb_sd_spi_arbiter.sv - scoreboard bench for sd_spi_arbiter with an SPI card model
module tb_sd_spi_arbiter;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       ck14, ck7;
  logic       c0_start, c1_start;
  logic [7:0] c0_txd, c1_txd;
  logic       c0_cs_n, c1_cs_n;
  logic       c0_busy, c1_busy, c0_done, c1_done;
  logic [7:0] c0_rxd, c1_rxd;
  logic       sd_miso, sd_sck, sd_mosi, sd_cs;
  logic [1:0] owner;

  always #5 clk28 = ~clk28;

  logic [1:0] ph = 2'd0;
  int         cyc = 0;
  always @(posedge clk28) begin
    ph  <= ph + 2'd1;
    cyc <= cyc + 1;
  end
  assign ck14 = ph[0];
  assign ck7  = (ph == 2'd3);

  sd_spi_arbiter #(.PRIO(1)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck14_i(ck14), .ck7_i(ck7),
    .c0_start_i(c0_start), .c0_txd_i(c0_txd), .c0_cs_n_i(c0_cs_n),
    .c0_busy_o(c0_busy), .c0_done_o(c0_done), .c0_rxd_o(c0_rxd),
    .c1_start_i(c1_start), .c1_txd_i(c1_txd), .c1_cs_n_i(c1_cs_n),
    .c1_busy_o(c1_busy), .c1_done_o(c1_done), .c1_rxd_o(c1_rxd),
    .sd_miso_i(sd_miso), .sd_sck_o(sd_sck), .sd_mosi_o(sd_mosi),
    .sd_cs_o(sd_cs), .owner_o(owner)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    tests++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Card model: MOSI captured on sck rise, MISO advanced on sck fall.
  logic [7:0] resp_tab [0:31];
  logic [7:0] cur_resp;
  logic [7:0] mosi_sh = 8'h00;
  logic [7:0] mosi_got [$];
  int         sbit = 0;
  int         xfer = 0;
  int         cs_rises = 0;

  always_comb begin
    cur_resp = resp_tab[xfer];
    sd_miso  = cur_resp[3'(7 - sbit)];
  end

  always @(posedge sd_sck) mosi_sh = {mosi_sh[6:0], sd_mosi};

  always @(negedge sd_sck) begin
    sbit++;
    if (sbit == 8) begin
      sbit = 0;
      mosi_got.push_back(mosi_sh);
      xfer++;
    end
  end

  always @(posedge sd_cs) begin
    cs_rises++;
    if (sbit != 0) begin
      sbit = 0;
      xfer++;
    end
  end

  typedef struct {
    logic       cl;
    logic [7:0] tx;
    logic [7:0] rx;
  } xfer_t;

  xfer_t exp_q [$];
  xfer_t mon_e;
  int    nwire = 0;
  int    ndone = 0;
  int    last_done_cyc = 0;

  task automatic expect_xfer(input logic cl, input logic [7:0] tx, input logic [7:0] rx);
    xfer_t e;
    e.cl = cl;
    e.tx = tx;
    e.rx = rx;
    exp_q.push_back(e);
    resp_tab[nwire] = rx;
    nwire++;
  endtask

  task automatic reserve_wire(input logic [7:0] rx);
    resp_tab[nwire] = rx;
    nwire++;
  endtask

  always @(negedge clk28) begin
    if (c0_done || c1_done) begin
      ndone++;
      last_done_cyc = cyc;
      chk("done_one_client", 32'(c0_done & c1_done), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done c0=%0b c1=%0b, required none", c0_done, c1_done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_client", 32'(c1_done), 32'(mon_e.cl));
        chk("rxd", 32'(mon_e.cl ? c1_rxd : c0_rxd), 32'(mon_e.rx));
        if (mosi_got.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mosi_byte: got nothing on MOSI, required %0h", mon_e.tx);
        end else begin
          chk("mosi_byte", 32'(mosi_got.pop_front()), 32'(mon_e.tx));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic pulse(input logic cl, input logic [7:0] tx);
    if (cl) begin
      c1_start = 1'b1;
      c1_txd   = tx;
    end else begin
      c0_start = 1'b1;
      c0_txd   = tx;
    end
    @(negedge clk28);
    c0_start = 1'b0;
    c1_start = 1'b0;
  endtask

  task automatic wait_dones(input int n, input string name);
    int k = 0;
    while (ndone < n && k < 200) begin
      @(negedge clk28);
      k++;
    end
    chk(name, 32'(ndone >= n), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d1, snap, nd, k;
    for (int i = 0; i < 32; i++) resp_tab[i] = 8'hFF;
    rst_n    = 1'b0;
    c0_start = 1'b0;
    c1_start = 1'b0;
    c0_txd   = 8'h00;
    c1_txd   = 8'h00;
    c0_cs_n  = 1'b1;
    c1_cs_n  = 1'b1;
    idle(3);

    chk("rst_cs", 32'(sd_cs), 1);
    chk("rst_sck", 32'(sd_sck), 0);
    chk("rst_mosi", 32'(sd_mosi), 1);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'({c1_busy, c0_busy}), 0);
    chk("rst_done", 32'({c1_done, c0_done}), 0);
    chk("rst_rxd0", 32'(c0_rxd), 32'hFF);
    chk("rst_rxd1", 32'(c1_rxd), 32'hFF);
    rst_n = 1'b1;
    idle(2);

    // single byte
    c0_cs_n = 1'b0;
    idle(2);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_cs", 32'(sd_cs), 0);
    expect_xfer(1'b0, 8'hA5, 8'h3C);
    t0 = cyc;
    pulse(1'b0, 8'hA5);
    chk("single_busy", 32'(c0_busy), 1);
    wait_dones(1, "single_done_seen");
    chk_range("single_latency", last_done_cyc - t0, 32, 39);

    // start ignored while busy
    expect_xfer(1'b0, 8'h5A, 8'hC3);
    pulse(1'b0, 8'h5A);
    idle(12);
    chk("ignore_busy", 32'(c0_busy), 1);
    pulse(1'b0, 8'h00);
    wait_dones(2, "ignore_done_seen");
    idle(45);
    chk("ignore_one_done", 32'(ndone), 2);

    // back-to-back with start in the DONE cycle
    expect_xfer(1'b0, 8'h12, 8'h34);
    expect_xfer(1'b0, 8'h56, 8'h78);
    snap = cs_rises;
    pulse(1'b0, 8'h12);
    k = 0;
    while (!c0_done && k < 100) begin
      @(negedge clk28);
      k++;
    end
    chk("b2b_reach_done", 32'(c0_done), 1);
    d1 = cyc;
    chk("b2b_busy_low_in_done", 32'(c0_busy), 0);
    pulse(1'b0, 8'h56);
    wait_dones(4, "b2b_done_seen");
    chk_range("b2b_gap", last_done_cyc - d1, 32, 39);
    chk("b2b_cs_no_glitch", 32'(cs_rises - snap), 0);

    // lock hold
    expect_xfer(1'b0, 8'hAA, 8'h11);
    pulse(1'b0, 8'hAA);
    idle(6);
    c1_cs_n = 1'b0;
    pulse(1'b1, 8'h77);
    chk("lock_c1_busy", 32'(c1_busy), 1);
    wait_dones(5, "lock_first_done");
    expect_xfer(1'b0, 8'hBB, 8'h22);
    pulse(1'b0, 8'hBB);
    wait_dones(6, "lock_second_done");
    idle(10);
    chk("lock_c1_waiting", 32'(c1_busy), 1);
    chk("lock_owner_c0", 32'(owner), 32'h2);
    chk("lock_no_c1_byte", 32'(ndone), 6);
    expect_xfer(1'b1, 8'h77, 8'h99);
    c0_cs_n = 1'b1;
    idle(3);
    chk("lock_owner_c1", 32'(owner), 32'h3);
    chk("lock_cs_c1", 32'(sd_cs), 0);
    wait_dones(7, "lock_c1_done");
    c1_cs_n = 1'b1;
    idle(2);
    chk("lock_release_owner", 32'(owner), 0);
    chk("lock_release_cs", 32'(sd_cs), 1);

    // simultaneous request, PRIO=1
    expect_xfer(1'b1, 8'hC1, 8'hE1);
    expect_xfer(1'b0, 8'hC0, 8'hE0);
    c0_cs_n  = 1'b0;
    c1_cs_n  = 1'b0;
    c0_start = 1'b1;
    c0_txd   = 8'hC0;
    c1_start = 1'b1;
    c1_txd   = 8'hC1;
    @(negedge clk28);
    c0_start = 1'b0;
    c1_start = 1'b0;
    idle(1);
    chk("simul_owner_c1", 32'(owner), 32'h3);
    chk("simul_c0_waiting", 32'(c0_busy), 1);
    wait_dones(8, "simul_c1_done");
    c1_cs_n = 1'b1;
    idle(3);
    chk("simul_owner_c0", 32'(owner), 32'h2);
    wait_dones(9, "simul_c0_done");
    c0_cs_n = 1'b1;
    idle(2);
    chk("simul_release", 32'(owner), 0);

    // reset mid-SHIFT at bit 4
    reserve_wire(8'h55);
    c0_cs_n = 1'b0;
    idle(2);
    pulse(1'b0, 8'hF0);
    k = 0;
    while (!(sbit == 4 && !sd_sck) && k < 100) begin
      @(negedge clk28);
      k++;
    end
    chk("rstmid_reach_bit4", 32'(sbit), 4);
    nd = ndone;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs", 32'(sd_cs), 1);
    chk("rstmid_sck", 32'(sd_sck), 0);
    chk("rstmid_mosi", 32'(sd_mosi), 1);
    chk("rstmid_busy", 32'(c0_busy), 0);
    chk("rstmid_rxd", 32'(c0_rxd), 32'hFF);
    chk("rstmid_owner", 32'(owner), 0);
    idle(3);
    rst_n = 1'b1;
    chk("rstmid_no_done", 32'(ndone), 32'(nd));
    idle(2);
    expect_xfer(1'b0, 8'h3C, 8'hA5);
    pulse(1'b0, 8'h3C);
    wait_dones(nd + 1, "rstmid_fresh_done");
    chk("rstmid_fresh_rxd", 32'(c0_rxd), 32'hA5);
    c0_cs_n = 1'b1;
    idle(5);

    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
